// File: rtl/theta_parity_acc.sv
// theta_parity_acc: accumulates five Keccak planes into the column parity C[x].
// Optional theta D output is built when THETA_D_OUT_EN is defined.
module theta_parity_acc #(
    parameter int unsigned LANE_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5*LANE_W-1:0]   in_plane,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5*LANE_W-1:0]   out_c,
`ifdef THETA_D_OUT_EN
    output logic [5*LANE_W-1:0]   out_d,
`endif
    output logic [2:0]            beat_idx
);

    localparam int unsigned PLANE_W = 5 * LANE_W;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           beat_d;
    logic [PLANE_W-1:0]   acc_q;
    logic [PLANE_W-1:0]   acc_d;
    logic [PLANE_W-1:0]   c_d;
    logic [PLANE_W-1:0]   col;
    logic                 xfer;

    // Handshake: ready only while accumulating and not held in reset
    assign in_ready  = (state_q == ACC) && !rst;
    assign out_valid = (state_q == HOLD);
    assign xfer      = in_valid && in_ready;
    assign col       = acc_q ^ in_plane;

`ifdef THETA_D_OUT_EN
    logic [PLANE_W-1:0]   d_col;
    logic [PLANE_W-1:0]   d_d;

    // Theta D from the parity about to be registered: C[x-1] ^ rotl1(C[x+1])
    for (genvar x = 0; x < 5; x++) begin : g_d
        logic [LANE_W-1:0] c_m;
        logic [LANE_W-1:0] c_p;
        logic [LANE_W-1:0] c_rot;
        assign c_m = col[((x + 4) % 5) * LANE_W +: LANE_W];
        assign c_p = col[((x + 1) % 5) * LANE_W +: LANE_W];
        if (LANE_W == 1) begin : g_w1
            assign c_rot = c_p;
        end else begin : g_wn
            assign c_rot = {c_p[LANE_W-2:0], c_p[LANE_W-1]};
        end
        assign d_col[x*LANE_W +: LANE_W] = c_m ^ c_rot;
    end
`endif

    // Next-state, accumulator and result update
    always_comb begin
        state_d = state_q;
        beat_d  = beat_idx;
        acc_d   = acc_q;
        c_d     = out_c;
`ifdef THETA_D_OUT_EN
        d_d     = out_d;
`endif
        if (abort) begin
            state_d = ACC;
            beat_d  = 3'd0;
            acc_d   = '0;
            c_d     = '0;
`ifdef THETA_D_OUT_EN
            d_d     = '0;
`endif
        end else begin
            case (state_q)
                ACC: begin
                    if (xfer) begin
                        if (beat_idx == 3'd4) begin
                            c_d     = col;
`ifdef THETA_D_OUT_EN
                            d_d     = d_col;
`endif
                            beat_d  = 3'd0;
                            state_d = HOLD;
                        end else if (beat_idx == 3'd0) begin
                            acc_d  = in_plane;
                            beat_d = 3'd1;
                        end else begin
                            acc_d  = col;
                            beat_d = beat_idx + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACC;
            beat_idx <= 3'd0;
            acc_q    <= '0;
            out_c    <= '0;
`ifdef THETA_D_OUT_EN
            out_d    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            beat_idx <= beat_d;
            acc_q    <= acc_d;
            out_c    <= c_d;
`ifdef THETA_D_OUT_EN
            out_d    <= d_d;
`endif
        end
    end

endmodule

// File: tb/tb_theta_parity_acc.sv
// Scoreboard bench for theta_parity_acc (64-bit and 8-bit lane instances).
module tb_theta_parity_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 64-bit lane instance
    logic         rst, abort, in_valid, in_ready, out_valid, out_ready;
    logic [319:0] in_plane, out_c;
    logic [2:0]   beat_idx;
`ifdef THETA_D_OUT_EN
    logic [319:0] out_d;
`endif

    theta_parity_acc #(.LANE_W(64)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_plane(in_plane),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
`ifdef THETA_D_OUT_EN
        .out_d(out_d),
`endif
        .beat_idx(beat_idx)
    );

    // 8-bit lane instance
    logic        rst8, abort8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [39:0] in_plane8, out_c8;
    logic [2:0]  beat_idx8;
`ifdef THETA_D_OUT_EN
    logic [39:0] out_d8;
`endif

    theta_parity_acc #(.LANE_W(8)) dut8 (
        .clk(clk), .rst(rst8), .abort(abort8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_plane(in_plane8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_c(out_c8),
`ifdef THETA_D_OUT_EN
        .out_d(out_d8),
`endif
        .beat_idx(beat_idx8)
    );

    logic [319:0] qc[$];
    logic [319:0] qd[$];
    logic [39:0]  qc8[$];
    logic [39:0]  qd8[$];

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [319:0] mk(input logic [63:0] l0, input logic [63:0] l1,
                                        input logic [63:0] l2, input logic [63:0] l3,
                                        input logic [63:0] l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    // Monitor: compare each cycle a result is presented, retire it when taken
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (qc.size() == 0) begin
                chk("unexpected_out64", 320'(out_valid), 320'd0);
            end else begin
                chk("out_c64", out_c, qc[0]);
`ifdef THETA_D_OUT_EN
                chk("out_d64", out_d, qd[0]);
`endif
                if (out_ready) begin
                    void'(qc.pop_front());
                    void'(qd.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst8 && out_valid8) begin
            if (qc8.size() == 0) begin
                chk("unexpected_out8", 320'(out_valid8), 320'd0);
            end else begin
                chk("out_c8", 320'(out_c8), 320'(qc8[0]));
`ifdef THETA_D_OUT_EN
                chk("out_d8", 320'(out_d8), 320'(qd8[0]));
`endif
                if (out_ready8) begin
                    void'(qc8.pop_front());
                    void'(qd8.pop_front());
                end
            end
        end
    end

    task automatic send64(input logic [319:0] p);
        in_valid = 1'b1;
        in_plane = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_plane = '0;
    endtask

    task automatic send8(input logic [39:0] p);
        in_valid8 = 1'b1;
        in_plane8 = p;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_plane8 = '0;
    endtask

    task automatic drain64(input string nm);
        for (int i = 0; i < 20 && qc.size() != 0; i++) @(negedge clk);
        if (qc.size() != 0) begin
            chk(nm, 320'(qc.size()), 320'd0);
            qc.delete();
            qd.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [319:0] rep;
    localparam logic [63:0] L   = 64'hFFFF_0000_A5A5_1234;
    localparam logic [63:0] LD  = 64'h0001_0001_EEEF_365D;
    localparam logic [63:0] JNK = 64'hDEAD_BEEF_0BAD_F00D;

    initial begin
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_plane = '0; out_ready = 1'b1;
        rst8 = 1'b1; abort8 = 1'b0; in_valid8 = 1'b0; in_plane8 = '0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 320'(in_ready), 320'd0);
        chk("rst_out_valid", 320'(out_valid), 320'd0);
        chk("rst_beat", 320'(beat_idx), 320'd0);
        chk("rst_out_c", out_c, 320'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 320'(in_ready), 320'd1);
        @(posedge clk);
        #1;

        // All-zero planes
        qc.push_back('0); qd.push_back('0);
        repeat (4) send64('0);
        @(negedge clk);
        chk("zero_beat4", 320'(beat_idx), 320'd4);
        chk("zero_not_yet_valid", 320'(out_valid), 320'd0);
        send64('0);
        @(negedge clk);
        chk("zero_latency", 320'(out_valid), 320'd1);
        drain64("zero_timeout");

        // Single bit in lane 0 of plane 0, with idle cycles between beats
        qc.push_back(mk(64'd1, 0, 0, 0, 0));
        qd.push_back(mk(0, 64'd1, 0, 0, 64'd2));
        send64(mk(64'd1, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_hold_beat", 320'(beat_idx), 320'd1);
        repeat (4) send64('0);
        drain64("single_timeout");

        // Same plane five times with backpressure on the result
        rep = mk(L, L, L, L, L);
        out_ready = 1'b0;
        qc.push_back(rep);
        qd.push_back(mk(LD, LD, LD, LD, LD));
        repeat (5) send64(rep);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 320'(out_valid), 320'd1);
            chk("bp_in_ready", 320'(in_ready), 320'd0);
            in_valid = 1'b1;
            in_plane = mk(JNK, JNK, JNK, JNK, JNK);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_plane = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready", 320'(in_ready), 320'd1);
        chk("bp_release_out_valid", 320'(out_valid), 320'd0);
        chk("bp_release_beat", 320'(beat_idx), 320'd0);
        drain64("bp_timeout");

        // Abort after three beats, with a simultaneous transfer
        repeat (3) send64(mk(JNK, ~JNK, JNK, ~JNK, JNK));
        @(negedge clk);
        chk("abort_pre_beat", 320'(beat_idx), 320'd3);
        abort = 1'b1;
        in_valid = 1'b1;
        in_plane = mk(~JNK, JNK, ~JNK, JNK, ~JNK);
        @(posedge clk);
        #1;
        abort = 1'b0;
        in_valid = 1'b0;
        in_plane = '0;
        @(negedge clk);
        chk("abort_beat", 320'(beat_idx), 320'd0);
        chk("abort_out_valid", 320'(out_valid), 320'd0);
        qc.push_back(mk(64'd1, 64'd2, 64'd4, 64'd8, 64'd16));
        qd.push_back(mk(64'd20, 64'd9, 64'd18, 64'd36, 64'd10));
        send64(mk(64'd3, 0, 0, 0, 0));
        send64(mk(0, 64'd2, 0, 0, 0));
        send64(mk(0, 0, 64'd4, 0, 0));
        send64(mk(0, 0, 0, 64'd8, 0));
        send64(mk(64'd2, 0, 0, 0, 64'd16));
        drain64("abort_timeout");

        // Reset in the middle of an accumulation
        repeat (2) send64(mk(JNK, JNK, ~JNK, JNK, JNK));
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_beat", 320'(beat_idx), 320'd0);
        chk("midrst_in_ready", 320'(in_ready), 320'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        qc.push_back(mk(64'd1, 0, 0, 0, 0));
        qd.push_back(mk(0, 64'd1, 0, 0, 64'd2));
        send64(mk(64'd1, 0, 0, 0, 0));
        repeat (4) send64('0);
        drain64("midrst_timeout");

        // 8-bit lanes: rotate wrap, then reset while holding the result
        out_ready8 = 1'b0;
        qc8.push_back(40'h00_00_00_80_00);
        qd8.push_back(40'h00_00_80_00_01);
        send8(40'h00_00_00_80_00);
        repeat (4) send8('0);
        @(negedge clk);
        chk("w8_out_valid", 320'(out_valid8), 320'd1);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(negedge clk);
        chk("w8_rst_in_ready", 320'(in_ready8), 320'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w8_rst_out_valid", 320'(out_valid8), 320'd0);
        chk("w8_rst_out_c", 320'(out_c8), 320'd0);
        chk("w8_rst_q_empty", 320'(qc8.size()), 320'd1);
        qc8.delete();
        qd8.delete();
        rst8 = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/theta_parity_acc.md
THETA_PARITY_ACC -- requirements
Module: theta_parity_acc

Interface
REQ-001 SHALL have parameter LANE_W, default 64, meaning lane width in bits (Keccak-f[25*LANE_W]); legal values 1,2,4,8,16,32,64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port abort  input  1  synchronous discard of any partial accumulation or held result.
REQ-005 SHALL have port in_valid  input  1  in_plane carries a valid plane.
REQ-006 SHALL have port in_ready  output  1  block accepts a plane this cycle.
REQ-007 SHALL have port in_plane  input  5*LANE_W  one plane y, lane x at bits [x*LANE_W +: LANE_W], little-endian.
REQ-008 SHALL have port out_valid  output  1  out_c (and out_d) hold a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out_c  output  5*LANE_W  column parity C[x], lane x at bits [x*LANE_W +: LANE_W].
REQ-011 SHALL have port out_d  output  5*LANE_W  theta D[x], same packing; present only when THETA_D_OUT_EN is defined.
REQ-012 SHALL have port beat_idx  output  3  number of planes accepted in the current accumulation, 0..4.

Function
REQ-013 SHALL accept a plane when in_valid && in_ready, the transfer condition.
REQ-014 SHALL implement two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL in ACC on transfer with beat_idx=0 load acc <= in_plane (no XOR with stale data).
REQ-016 SHALL in ACC on transfer with beat_idx=1..3 set acc <= acc ^ in_plane and increment beat_idx.
REQ-017 SHALL on transfer with beat_idx=4 register out_c <= acc ^ in_plane, set beat_idx to 0, and enter HOLD, with out_valid high the next cycle (1-cycle latency after the fifth beat).
REQ-018 SHALL hold beat_idx and acc unchanged in ACC cycles without a transfer.
REQ-019 SHALL in HOLD keep out_c/out_d stable while out_ready=0, for any number of cycles.
REQ-020 SHALL in HOLD on out_ready=1 return to ACC the next cycle; in_ready rises that cycle, and there is no same-cycle overlap.
REQ-021 SHALL on abort=1 (either state) return to ACC with beat_idx=0 and out_valid=0 next cycle; abort takes priority over a simultaneous transfer, which is discarded, and over out_ready.
REQ-022 SHALL compute C[x] = XOR over y=0..4 of A[x,y] per bit z; it has no carries, so results are width-exact.
REQ-023 SHALL drive in_ready=0 combinationally while rst=1.

Reset
REQ-024 SHALL on rst=1 set state ACC, beat_idx 0, acc 0, out_valid 0, out_c 0, out_d 0 the next edge; rst overrides abort and all handshakes.
REQ-025 SHALL, when rst asserts mid-accumulation or in HOLD, drop all partial and held data; the first plane after reset is beat 0.

Configuration
REQ-026 SHALL, with THETA_D_OUT_EN defined, register out_d with out_c, where D[x] = C[(x+4)%5] ^ ROTL1(C[(x+1)%5]); ROTL1 moves bit z to bit (z+1) mod LANE_W, and is identity for LANE_W=1.
REQ-027 SHALL, without THETA_D_OUT_EN, omit port out_d and all D logic; other behaviour is identical.

Verification
REQ-028 SHALL verify zeros: LANE_W=64, five planes all-zero -> out_valid after 5th beat +1 cycle, out_c=0, out_d=0.
REQ-029 SHALL verify single bit: LANE_W=64, plane y=0 lane0=1, planes 1..4 zero -> out_c lane0=1, other lanes 0; out_d lane1=1, lane4=2, others 0.
REQ-030 SHALL verify odd repeat: LANE_W=64, same plane {5 lanes = 64'hFFFF_0000_A5A5_1234} sent 5 times -> out_c equals that plane.
REQ-031 SHALL verify backpressure: hold out_ready=0 for 3 cycles in HOLD -> out_valid=1 and out_c stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-032 SHALL verify abort: accept 3 beats, then abort=1 with in_valid=1 -> beat_idx=0, beat discarded; next 5 clean beats give the correct C uncontaminated by the aborted data.
REQ-033 SHALL verify wrap: LANE_W=8, C lane1=8'h80 only -> out_d lane2=8'h80 and lane0=8'h01 (rotate wrap); also rst asserted in HOLD -> out_valid=0, out_c=0 next cycle.
